// File: rtl/seq_mul_ctrl_if.sv
// Request/response bundle between the EX stage and the sequential multiplier.
// The pipeline drives the request side (master); the multiplier answers (slave).
interface seq_mul_ctrl_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result
    );
endinterface

// File: rtl/seq_mul_ctrl.sv
// Multi-cycle shift-and-add multiplier for MUL/MULH/MULHSU/MULHU.
// Works on operand magnitudes with one shared ripple adder, then applies the
// sign with a two's complement pass before presenting the selected half.

// One full-adder cell; the shared adder is a ripple chain of these.
module seq_mul_ctrl_fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);
endmodule

module seq_mul_ctrl #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_mul_ctrl_if.slave  bus
);
    localparam int CW = (XLEN > 2) ? $clog2(XLEN) : 1;
    localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [1:0]      op_reg, op_next;
    logic [XLEN-1:0] mag_a_reg, mag_a_next;
    logic [XLEN-1:0] acc_hi_reg, acc_hi_next;
    logic [XLEN-1:0] acc_lo_reg, acc_lo_next;
    logic            neg_reg, neg_next;
    logic [XLEN-1:0] result_reg, result_next;

    // Operand conditioning: signedness per opcode, magnitudes and product sign.
    logic            a_neg_w, b_neg_w;
    logic [XLEN-1:0] mag_a_w, mag_b_w;
    assign a_neg_w = (bus.op != 2'b11) & bus.a[XLEN-1];
    assign b_neg_w = ~bus.op[1] & bus.b[XLEN-1];
    assign mag_a_w = a_neg_w ? (~bus.a + ONE) : bus.a;
    assign mag_b_w = b_neg_w ? (~bus.b + ONE) : bus.b;

    // Shared (XLEN+1)-bit ripple adder.
    logic [XLEN:0] add_x, add_y, add_sum;
    logic [XLEN:0] carry;
    logic          add_cin;
    assign carry[0] = add_cin;

    generate
        for (genvar gi = 0; gi <= XLEN; gi++) begin : g_adder
            if (gi < XLEN) begin : g_cell
                seq_mul_ctrl_fa u_fa (
                    .x  (add_x[gi]),
                    .y  (add_y[gi]),
                    .ci (carry[gi]),
                    .s  (add_sum[gi]),
                    .co (carry[gi+1])
                );
            end else begin : g_top
                // Top bit never overflows: both operands are zero-extended.
                assign add_sum[gi] = add_x[gi] ^ add_y[gi] ^ carry[gi];
            end
        end
    endgenerate

    // Adder operand selection: partial-product add in CALC, +1 of the
    // inverted low half in FIX.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        case (state_reg)
            S_CALC: begin
                add_x = {1'b0, acc_hi_reg};
                add_y = acc_lo_reg[0] ? {1'b0, mag_a_reg} : '0;
            end
            S_FIX: begin
                add_x   = {1'b0, ~acc_lo_reg};
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (bus.start) state_next = S_CALC;
            S_CALC:  if (cnt_reg == CNT_LAST) state_next = S_FIX;
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state; result comes straight from its register.
    always_comb begin
        bus.busy   = (state_reg == S_CALC) || (state_reg == S_FIX);
        bus.done   = (state_reg == S_DONE);
        bus.result = result_reg;
    end

    // Datapath next values: capture, shift-and-add, sign fix, result select.
    logic [XLEN-1:0] fix_hi_w, fix_lo_w;
    always_comb begin
        state_next_unused_guard: begin end
        cnt_next    = cnt_reg;
        op_next     = op_reg;
        mag_a_next  = mag_a_reg;
        acc_hi_next = acc_hi_reg;
        acc_lo_next = acc_lo_reg;
        neg_next    = neg_reg;
        result_next = result_reg;
        fix_lo_w    = acc_lo_reg;
        fix_hi_w    = acc_hi_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    op_next     = bus.op;
                    mag_a_next  = mag_a_w;
                    acc_hi_next = '0;
                    acc_lo_next = mag_b_w;
                    neg_next    = a_neg_w ^ b_neg_w;
                    cnt_next    = '0;
                end
            end
            S_CALC: begin
                acc_hi_next = add_sum[XLEN:1];
                acc_lo_next = {add_sum[0], acc_lo_reg[XLEN-1:1]};
                cnt_next    = cnt_reg + CNT_ONE;
            end
            S_FIX: begin
                if (neg_reg) begin
                    // Low half carry-out ripples into the inverted high half.
                    fix_lo_w = add_sum[XLEN-1:0];
                    fix_hi_w = ~acc_hi_reg + {{(XLEN-1){1'b0}}, add_sum[XLEN]};
                end
                acc_lo_next = fix_lo_w;
                acc_hi_next = fix_hi_w;
                result_next = (op_reg == 2'b00) ? fix_lo_w : fix_hi_w;
            end
            default: ;
        endcase
    end

    // Datapath registers, cleared by reset so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            op_reg     <= '0;
            mag_a_reg  <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            neg_reg    <= 1'b0;
            result_reg <= '0;
        end else begin
            cnt_reg    <= cnt_next;
            op_reg     <= op_next;
            mag_a_reg  <= mag_a_next;
            acc_hi_reg <= acc_hi_next;
            acc_lo_reg <= acc_lo_next;
            neg_reg    <= neg_next;
            result_reg <= result_next;
        end
    end
endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Self-checking bench for seq_mul_ctrl: directed corner cases plus random
// operations compared against a plain 64-bit arithmetic model.
module tb_seq_mul_ctrl;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seq_mul_ctrl_if #(.XLEN(XLEN)) bus ();

    seq_mul_ctrl #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: full signed/unsigned 64-bit product, pick the requested half.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] p;
        sa = (op != 2'b11) ? 64'($signed(a)) : {32'b0, a};
        sb = (op[1] == 1'b0) ? 64'($signed(b)) : {32'b0, b};
        p  = sa * sb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Issue one operation from an IDLE cycle (called #1 after a posedge);
    // with noise, inputs and stray start pulses are scrambled while in flight.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit noise);
        logic [31:0] exp;
        exp = ref_mul(op, a, b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        for (int k = 0; k <= XLEN; k++) begin
            check("busy_phase", {62'b0, bus.busy, bus.done}, 64'b10);
            if (noise) begin
                bus.start = (k == 9) ? 1'b1 : 1'($urandom_range(0, 1));
                bus.op    = 2'($urandom);
                bus.a     = (k == 9) ? 32'd9 : $urandom;
                bus.b     = (k == 9) ? 32'd9 : $urandom;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        check("done_phase", {62'b0, bus.busy, bus.done}, 64'b01);
        check("result", {32'b0, bus.result}, {32'b0, exp});
        bus.start = noise ? 1'b1 : 1'b0;
        @(posedge clk); #1;
        check("after_done", {62'b0, bus.busy, bus.done}, 64'b00);
        check("result_hold", {32'b0, bus.result}, {32'b0, exp});
        bus.start = 1'b0;
        $display("op=%0d a=%h b=%h result=%h expected=%h", op, a, b, bus.result, exp);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {31'b0, bus.busy, bus.done, bus.result}, 64'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", {31'b0, bus.busy, bus.done, bus.result}, 64'b0);

        run_op(2'b00, 32'd6, 32'd7, 1'b0);
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b01, 32'h0000_0000, 32'h1234_5678, 1'b0);
        run_op(2'b00, 32'd3, 32'd5, 1'b1);
        run_op(2'b00, 32'd11, 32'd13, 1'b0);

        // Asynchronous abort partway through an operation.
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 32'h1234;
        bus.b     = 32'h5678;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_async", {31'b0, bus.busy, bus.done, bus.result}, 64'b0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_held", {31'b0, bus.busy, bus.done, bus.result}, 64'b0);
        rst_n = 1'b1;
        for (int k = 0; k < XLEN + 4; k++) begin
            @(posedge clk); #1;
            check("no_done_after_abort", {62'b0, bus.busy, bus.done}, 64'b00);
        end
        run_op(2'b00, 32'd2, 32'd3, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom), pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
